// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO bank with 2**CH_W channels. Each channel has an
// output register, a synchronised and debounced input, a sticky change-status
// register (write-1-to-clear) and an interrupt enable mask.
module gpio_bank #(
    parameter int CH_W       = 1,
    parameter int DW         = 16,
    parameter int DEB_CYCLES = 20000,
    parameter int CNT_W      = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        cs_i,
    input  logic                        write_i,
    input  logic                        read_i,
    input  logic [CH_W+1:0]             addr_i,
    input  logic [DW-1:0]               wdata_i,
    output logic [DW-1:0]               rdata_o,
    input  logic [DW*(2**CH_W)-1:0]     gpio_in_i,
    output logic [DW*(2**CH_W)-1:0]     gpio_out_o,
    output logic                        irq_o
);

    localparam int NCH = 2**CH_W;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    localparam logic [1:0] REG_OUT  = 2'd0;
    localparam logic [1:0] REG_IN   = 2'd1;
    localparam logic [1:0] REG_STAT = 2'd2;
    localparam logic [1:0] REG_IEN  = 2'd3;

    // Channel c occupies element c, which flattens to bits [c*DW +: DW].
    logic [NCH-1:0][DW-1:0]    out_q,      out_d;
    logic [NCH-1:0][DW-1:0]    ien_q,      ien_d;
    logic [NCH-1:0][DW-1:0]    stat_q,     stat_d;
    logic [NCH-1:0][DW-1:0]    stable_q,   stable_d;
    logic [NCH-1:0][CNT_W-1:0] debCnt_q,   debCnt_d;
    logic [NCH-1:0][DW-1:0]    syncMeta_q;
    logic [NCH-1:0][DW-1:0]    sync_q;
    logic                      irq_q,      irq_d;

    logic [CH_W-1:0] chSel;
    logic [1:0]      regSel;
    logic            wrEn;
    logic [DW-1:0]   setBits;
    logic [DW-1:0]   clrBits;

    assign chSel  = addr_i[CH_W+1:2];
    assign regSel = addr_i[1:0];
    assign wrEn   = cs_i & write_i;

    // Next-state for bus writes, debounce counters, sticky status and the irq OR.
    always_comb begin
        out_d    = out_q;
        ien_d    = ien_q;
        stat_d   = stat_q;
        stable_d = stable_q;
        debCnt_d = debCnt_q;
        irq_d    = 1'b0;
        setBits  = '0;
        clrBits  = '0;
        for (int c = 0; c < NCH; c++) begin
            setBits = '0;
            clrBits = '0;

            if (wrEn && chSel == CH_W'(c)) begin
                case (regSel)
                    REG_OUT:  out_d[c] = wdata_i;
                    REG_STAT: clrBits  = wdata_i;
                    REG_IEN:  ien_d[c] = wdata_i;
                    default:  ;
                endcase
            end

            // The count only restarts when sync falls back to the stable value;
            // a different non-stable value keeps counting toward itself.
            if (sync_q[c] != stable_q[c]) begin
                if (debCnt_q[c] == DEB_LAST) begin
                    stable_d[c] = sync_q[c];
                    debCnt_d[c] = '0;
                    setBits     = sync_q[c] ^ stable_q[c];
                end else begin
                    debCnt_d[c] = debCnt_q[c] + 1'b1;
                end
            end else begin
                debCnt_d[c] = '0;
            end

            // A new change wins over a simultaneous clear of the same bit.
            stat_d[c] = (stat_q[c] & ~clrBits) | setBits;
            irq_d     = irq_d | (|(stat_d[c] & ien_d[c]));
        end
    end

    // State registers, input synchroniser and registered irq, all cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q      <= '0;
            ien_q      <= '0;
            stat_q     <= '0;
            stable_q   <= '0;
            debCnt_q   <= '0;
            syncMeta_q <= '0;
            sync_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            out_q      <= out_d;
            ien_q      <= ien_d;
            stat_q     <= stat_d;
            stable_q   <= stable_d;
            debCnt_q   <= debCnt_d;
            syncMeta_q <= gpio_in_i;
            sync_q     <= syncMeta_q;
            irq_q      <= irq_d;
        end
    end

    // Zero-latency read mux; shows pre-write contents when a write hits the same register.
    always_comb begin
        rdata_o = '0;
        if (cs_i && read_i) begin
            case (regSel)
                REG_OUT:  rdata_o = out_q[chSel];
                REG_IN:   rdata_o = stable_q[chSel];
                REG_STAT: rdata_o = stat_q[chSel];
                REG_IEN:  rdata_o = ien_q[chSel];
                default:  rdata_o = '0;
            endcase
        end
    end

    assign gpio_out_o = out_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed self-checking bench for gpio_bank with DEB_CYCLES=4.
module tb_gpio_bank;

    localparam int CH_W  = 1;
    localparam int DW    = 16;
    localparam int DEB   = 4;
    localparam int CNT_W = 16;
    localparam int NCH   = 2**CH_W;
    localparam int AW    = CH_W + 2;

    localparam int R_OUT  = 0;
    localparam int R_IN   = 1;
    localparam int R_STAT = 2;
    localparam int R_IEN  = 3;

    logic              clk;
    logic              rstN;
    logic              cs;
    logic              wr;
    logic              rd;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
    logic [DW-1:0]     rdata;
    logic [DW*NCH-1:0] gpioIn;
    logic [DW*NCH-1:0] gpioOut;
    logic              irq;

    int checks = 0;
    int errors = 0;

    gpio_bank #(
        .CH_W       (CH_W),
        .DW         (DW),
        .DEB_CYCLES (DEB),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rstN),
        .cs_i       (cs),
        .write_i    (wr),
        .read_i     (rd),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .rdata_o    (rdata),
        .gpio_in_i  (gpioIn),
        .gpio_out_o (gpioOut),
        .irq_o      (irq)
    );

    // Long period so several 1 ns read probes fit between edges.
    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    function automatic logic [AW-1:0] regAddr(input int ch, input int r);
        return AW'(ch * 4 + r);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [DW*NCH-1:0] value);
        gpioIn = value;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic busWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cs    = 1'b1;
        wr    = 1'b1;
        addr  = a;
        wdata = d;
        tick(1);
        cs    = 1'b0;
        wr    = 1'b0;
        wdata = '0;
    endtask

    task automatic checkRead(input string tag, input logic [AW-1:0] a,
                             input logic [DW-1:0] expected);
        cs   = 1'b1;
        rd   = 1'b1;
        addr = a;
        #1;
        checkOutput(tag, 32'(rdata), 32'(expected));
        cs   = 1'b0;
        rd   = 1'b0;
    endtask

    initial begin
        rstN = 1'b1;
        cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
        applyStimulus($urandom);

        // Asynchronous reset, no clock edge needed.
        #1 rstN = 1'b0;
        #1;
        checkOutput("rstGpioOut", gpioOut, 32'h0);
        checkOutput("rstIrq", 32'(irq), 32'h0);
        checkOutput("rstRdataIdle", 32'(rdata), 32'h0);
        applyStimulus($urandom);
        tick(3);
        checkOutput("rstHoldGpioOut", gpioOut, 32'h0);
        checkRead("rstHoldIn", regAddr(0, R_IN), 16'h0000);

        // Release with quiet inputs.
        applyStimulus('0);
        rstN = 1'b1;
        tick(10);
        checkRead("postRstIn", regAddr(0, R_IN), 16'h0000);
        checkOutput("postRstIrq", 32'(irq), 32'h0);

        // OUT write and readback on channel 1.
        busWrite(regAddr(1, R_OUT), 16'hA5C3);
        checkOutput("outCh1Pins", gpioOut, 32'hA5C3_0000);
        checkRead("outCh1Read", regAddr(1, R_OUT), 16'hA5C3);
        checkRead("outCh0Read", regAddr(0, R_OUT), 16'h0000);

        // rdata must be zero unless both cs and read are high.
        cs = 1'b1; rd = 1'b0; addr = regAddr(1, R_OUT); #1;
        checkOutput("rdataNoRead", 32'(rdata), 32'h0);
        cs = 1'b0; rd = 1'b1; #1;
        checkOutput("rdataNoCs", 32'(rdata), 32'h0);
        rd = 1'b0;

        // IN is read-only.
        busWrite(regAddr(0, R_IN), 16'hFFFF);
        checkRead("inWriteIgnored", regAddr(0, R_IN), 16'h0000);

        // Simultaneous read and write: read shows the old value.
        cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = regAddr(1, R_OUT); wdata = 16'h5A5A; #1;
        checkOutput("rdWrSame", 32'(rdata), 32'h0000_A5C3);
        tick(1);
        cs = 1'b0; rd = 1'b0; wr = 1'b0; wdata = '0;
        checkOutput("rdWrPins", gpioOut, 32'h5A5A_0000);

        // Three-sample glitch is rejected.
        applyStimulus(32'h0000_0001);
        tick(3);
        applyStimulus(32'h0000_0000);
        tick(6);
        checkRead("glitchIn", regAddr(0, R_IN), 16'h0000);
        checkRead("glitchStat", regAddr(0, R_STAT), 16'h0000);

        // Held change appears exactly 2+DEB edges after the first sampling edge.
        applyStimulus(32'h0000_0001);
        tick(5);
        checkRead("heldInEarly", regAddr(0, R_IN), 16'h0000);
        tick(1);
        checkRead("heldIn", regAddr(0, R_IN), 16'h0001);
        checkRead("heldStat", regAddr(0, R_STAT), 16'h0001);
        checkOutput("heldIrqMasked", 32'(irq), 32'h0);

        // Enabling the pending bit raises irq the cycle after the write.
        busWrite(regAddr(0, R_IEN), 16'h0001);
        checkOutput("ienIrq", 32'(irq), 32'h1);
        checkRead("ienRead", regAddr(0, R_IEN), 16'h0001);
        busWrite(regAddr(0, R_STAT), 16'h0001);
        checkOutput("w1cIrq", 32'(irq), 32'h0);
        checkRead("w1cStat", regAddr(0, R_STAT), 16'h0000);

        // A 1->0 change also sets STAT and raises irq on the commit edge.
        applyStimulus(32'h0000_0000);
        tick(5);
        checkOutput("toggleIrqEarly", 32'(irq), 32'h0);
        tick(1);
        checkOutput("toggleIrq", 32'(irq), 32'h1);
        checkRead("toggleIn", regAddr(0, R_IN), 16'h0000);
        checkRead("toggleStat", regAddr(0, R_STAT), 16'h0001);

        // Clear on the same edge a new change commits: set wins.
        busWrite(regAddr(0, R_STAT), 16'h0001);
        checkOutput("preCollIrq", 32'(irq), 32'h0);
        applyStimulus(32'h0000_0001);
        tick(5);
        busWrite(regAddr(0, R_STAT), 16'h0001);
        checkRead("collStat", regAddr(0, R_STAT), 16'h0001);
        checkRead("collIn", regAddr(0, R_IN), 16'h0001);
        checkOutput("collIrq", 32'(irq), 32'h1);

        // Clearing bits that are already 0 changes nothing.
        busWrite(regAddr(0, R_STAT), 16'hFFFE);
        checkRead("w1cZeroStat", regAddr(0, R_STAT), 16'h0001);
        checkOutput("w1cZeroIrq", 32'(irq), 32'h1);

        // Channel 1 input path and irq OR across channels.
        applyStimulus(32'h8000_0001);
        tick(6);
        checkRead("ch1In", regAddr(1, R_IN), 16'h8000);
        checkRead("ch1Stat", regAddr(1, R_STAT), 16'h8000);
        checkRead("ch0Steady", regAddr(0, R_IN), 16'h0001);
        busWrite(regAddr(1, R_IEN), 16'h8000);
        busWrite(regAddr(0, R_STAT), 16'h0001);
        checkOutput("ch1Irq", 32'(irq), 32'h1);
        busWrite(regAddr(1, R_STAT), 16'h8000);
        checkOutput("ch1IrqClr", 32'(irq), 32'h0);

        // Reset two cycles into a count discards it and the stable value.
        applyStimulus(32'h8000_0003);
        tick(4);
        rstN = 1'b0;
        #1;
        checkOutput("midRstGpioOut", gpioOut, 32'h0);
        checkRead("midRstIn", regAddr(1, R_IN), 16'h0000);
        tick(2);
        rstN = 1'b1;
        tick(5);
        checkRead("relInEarly", regAddr(0, R_IN), 16'h0000);
        tick(1);
        checkRead("relInCh0", regAddr(0, R_IN), 16'h0003);
        checkRead("relInCh1", regAddr(1, R_IN), 16'h8000);
        checkRead("relStatCh0", regAddr(0, R_STAT), 16'h0003);
        checkRead("relOutCh1", regAddr(1, R_OUT), 16'h0000);
        checkOutput("relIrq", 32'(irq), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
